// File: rtl/m72_irq_if.sv
// M72 interrupt controller bus bundle: CPU register port, interrupt
// sources, V30 acknowledge handshake and timing-block load port.
interface m72_irq_if;
  logic        CPU_WR;
  logic [1:0]  CPU_ADDR;
  logic [15:0] CPU_DIN;
  logic [15:0] CPU_DOUT;
  logic [3:0]  IRQ_SRC;
  logic        INTA;
  logic        INTR;
  logic [7:0]  VEC;
  logic        VEC_VALID;
  logic        ISET;
  logic [15:0] TD;

  modport master (
    output CPU_WR, CPU_ADDR, CPU_DIN, IRQ_SRC, INTA,
    input  CPU_DOUT, INTR, VEC, VEC_VALID, ISET, TD
  );

  modport slave (
    input  CPU_WR, CPU_ADDR, CPU_DIN, IRQ_SRC, INTA,
    output CPU_DOUT, INTR, VEC, VEC_VALID, ISET, TD
  );
endinterface

// File: rtl/m72_irq_ctrl.sv
// M72 interrupt controller and raster-line loader for the video timing block.
//
// state   | meaning
// S_IDLE  | no acknowledge in progress; first INTA latches the selection
// S_ACK1  | first INTA seen; second INTA delivers the latched vector
module m72_irq_ctrl #(
  parameter logic [7:0] VEC_BASE       = 8'h20,
  parameter logic [7:0] SPURIOUS_VEC   = 8'h27,
  parameter logic [8:0] RASTER_DEFAULT = 9'd0
) (
  input logic      CLK_32M,
  input logic      RESET_N,
  m72_irq_if.slave bus
);

  typedef enum logic {S_IDLE, S_ACK1} state_t;

  state_t      state_q, state_d;
  logic [3:0]  src_prev_q;
  logic [3:0]  pending_q, pending_d;
  logic [3:0]  in_service_q, in_service_d;
  logic [3:0]  mask_q, mask_d;
  logic [8:0]  raster_q, raster_d;
  logic        sel_valid_q, sel_valid_d;
  logic [1:0]  sel_idx_q, sel_idx_d;
  logic        intr_q, intr_d;
  logic [7:0]  vec_q, vec_d;
  logic        vec_valid_q, vec_valid_d;
  logic        iset_q, iset_d;
  logic [15:0] td_q, td_d;
  logic        boot_q;

  logic [3:0]  rise, isv_low, allow, eligible, w1c, ack_clr, eoi_clr;
  logic [1:0]  pick;
  logic        wr_mask, wr_raster, wr_w1c, wr_eoi;

  assign wr_mask   = bus.CPU_WR && (bus.CPU_ADDR == 2'd0);
  assign wr_raster = bus.CPU_WR && (bus.CPU_ADDR == 2'd1);
  assign wr_w1c    = bus.CPU_WR && (bus.CPU_ADDR == 2'd2);
  assign wr_eoi    = bus.CPU_WR && (bus.CPU_ADDR == 2'd3);

  // Edge detect, nesting window and highest-priority eligible source.
  // Only sources below the lowest-index in-service bit may interrupt.
  always_comb begin
    rise     = bus.IRQ_SRC & ~src_prev_q;
    isv_low  = in_service_q & (~in_service_q + 4'd1);
    allow    = (in_service_q == 4'd0) ? 4'hF : (isv_low - 4'd1);
    eligible = pending_q & ~mask_q & allow;
    pick     = 2'd3;
    if (eligible[2]) pick = 2'd2;
    if (eligible[1]) pick = 2'd1;
    if (eligible[0]) pick = 2'd0;
  end

  // Acknowledge FSM: next state, selection latch and vector delivery.
  always_comb begin
    state_d     = state_q;
    sel_valid_d = sel_valid_q;
    sel_idx_d   = sel_idx_q;
    vec_d       = vec_q;
    vec_valid_d = 1'b0;
    ack_clr     = 4'd0;
    case (state_q)
      S_IDLE: begin
        if (bus.INTA) begin
          state_d     = S_ACK1;
          sel_valid_d = |eligible;
          sel_idx_d   = pick;
        end
      end
      S_ACK1: begin
        if (bus.INTA) begin
          state_d     = S_IDLE;
          vec_valid_d = 1'b1;
          if (sel_valid_q) begin
            vec_d   = VEC_BASE + {6'd0, sel_idx_q};
            ack_clr = 4'b0001 << sel_idx_q;
          end else begin
            vec_d = SPURIOUS_VEC;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Register file updates; a new edge always beats a clear of the same bit.
  always_comb begin
    w1c          = wr_w1c ? bus.CPU_DIN[3:0] : 4'd0;
    eoi_clr      = wr_eoi ? isv_low : 4'd0;
    pending_d    = (pending_q & ~w1c & ~ack_clr) | rise;
    in_service_d = (in_service_q & ~eoi_clr) | ack_clr;
    mask_d       = wr_mask ? bus.CPU_DIN[3:0] : mask_q;
    raster_d     = wr_raster ? bus.CPU_DIN[8:0] : raster_q;
    intr_d       = |eligible;
    iset_d       = wr_raster | boot_q;
    td_d         = td_q;
    if (wr_raster) begin
      td_d = {7'd0, bus.CPU_DIN[8:0]};
    end else if (boot_q) begin
      td_d = {7'd0, raster_q};
    end
  end

  // FSM state register; reset abandons any half-finished acknowledge.
  always_ff @(posedge CLK_32M) begin
    if (!RESET_N) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers; boot_q requests the post-reset raster load.
  always_ff @(posedge CLK_32M) begin
    if (!RESET_N) begin
      src_prev_q   <= bus.IRQ_SRC;
      pending_q    <= 4'd0;
      in_service_q <= 4'd0;
      mask_q       <= 4'hF;
      raster_q     <= RASTER_DEFAULT;
      sel_valid_q  <= 1'b0;
      sel_idx_q    <= 2'd0;
      intr_q       <= 1'b0;
      vec_q        <= 8'd0;
      vec_valid_q  <= 1'b0;
      iset_q       <= 1'b0;
      td_q         <= 16'd0;
      boot_q       <= 1'b1;
    end else begin
      src_prev_q   <= bus.IRQ_SRC;
      pending_q    <= pending_d;
      in_service_q <= in_service_d;
      mask_q       <= mask_d;
      raster_q     <= raster_d;
      sel_valid_q  <= sel_valid_d;
      sel_idx_q    <= sel_idx_d;
      intr_q       <= intr_d;
      vec_q        <= vec_d;
      vec_valid_q  <= vec_valid_d;
      iset_q       <= iset_d;
      td_q         <= td_d;
      boot_q       <= 1'b0;
    end
  end

  // Register read mux.
  always_comb begin
    bus.CPU_DOUT = 16'd0;
    case (bus.CPU_ADDR)
      2'd0:    bus.CPU_DOUT = {12'd0, mask_q};
      2'd1:    bus.CPU_DOUT = {7'd0, raster_q};
      2'd2:    bus.CPU_DOUT = {12'd0, pending_q};
      default: bus.CPU_DOUT = {12'd0, in_service_q};
    endcase
  end

  assign bus.INTR      = intr_q;
  assign bus.VEC       = vec_q;
  assign bus.VEC_VALID = vec_valid_q;
  assign bus.ISET      = iset_q;
  assign bus.TD        = td_q;

endmodule

// File: tb/tb_m72_irq_ctrl.sv
// Bench for m72_irq_ctrl: directed scenarios with literal expectations,
// then random traffic, all cross-checked every cycle against a
// behavioural model of the controller.
module tb_m72_irq_ctrl;
  localparam logic [7:0] VB = 8'h20;
  localparam logic [7:0] SP = 8'h27;
  localparam logic [8:0] RD = 9'd0;

  logic CLK_32M = 1'b0;
  logic RESET_N = 1'b0;
  int   checks  = 0;
  int   errors  = 0;

  m72_irq_if bus();

  m72_irq_ctrl #(.VEC_BASE(VB), .SPURIOUS_VEC(SP), .RASTER_DEFAULT(RD)) dut (
    .CLK_32M(CLK_32M),
    .RESET_N(RESET_N),
    .bus    (bus)
  );

  always #5 CLK_32M = ~CLK_32M;

  // model state (value of each output/register after the latest edge)
  logic [3:0]  m_pend, m_isv, m_mask, m_prev;
  logic [8:0]  m_raster;
  logic        m_intr, m_vv, m_iset, m_boot, m_inack;
  logic        m_valid = 1'b0;
  logic [7:0]  m_vec;
  logic [15:0] m_td;
  int          m_sel;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] exp_dout(input logic [1:0] a);
    case (a)
      2'd0:    return {12'd0, m_mask};
      2'd1:    return {7'd0, m_raster};
      2'd2:    return {12'd0, m_pend};
      default: return {12'd0, m_isv};
    endcase
  endfunction

  task automatic model_step();
    logic [3:0]  elig, np, ni;
    logic [7:0]  vec;
    logic [15:0] td;
    logic        vv, iset, inack, found;
    int          top, sel;
    if (!RESET_N) begin
      m_pend <= 4'd0; m_isv <= 4'd0; m_mask <= 4'hF; m_raster <= RD;
      m_intr <= 1'b0; m_vec <= 8'd0; m_vv <= 1'b0; m_iset <= 1'b0; m_td <= 16'd0;
      m_prev <= bus.IRQ_SRC; m_boot <= 1'b1; m_inack <= 1'b0; m_sel <= -1;
      m_valid <= 1'b1;
      return;
    end
    // the smallest in-service index is the level currently being serviced
    top = 4;
    for (int n = 3; n >= 0; n--) if (m_isv[n]) top = n;
    elig = 4'd0;
    for (int n = 0; n < 4; n++)
      if (m_pend[n] && !m_mask[n] && n < top) elig[n] = 1'b1;
    np = m_pend; ni = m_isv; vec = m_vec; vv = 1'b0; sel = m_sel; inack = m_inack;
    if (bus.CPU_WR && bus.CPU_ADDR == 2'd2) np = np & ~bus.CPU_DIN[3:0];
    if (bus.CPU_WR && bus.CPU_ADDR == 2'd3) begin
      found = 1'b0;
      for (int n = 0; n < 4; n++)
        if (m_isv[n] && !found) begin ni[n] = 1'b0; found = 1'b1; end
    end
    if (bus.INTA) begin
      if (!m_inack) begin
        inack = 1'b1;
        sel = -1;
        for (int n = 3; n >= 0; n--) if (elig[n]) sel = n;
      end else begin
        inack = 1'b0;
        vv = 1'b1;
        if (m_sel < 0) vec = SP;
        else begin
          vec = 8'(int'(VB) + m_sel);
          np[m_sel] = 1'b0;
          ni[m_sel] = 1'b1;
        end
      end
    end
    for (int n = 0; n < 4; n++)
      if (bus.IRQ_SRC[n] && !m_prev[n]) np[n] = 1'b1;
    iset = 1'b0; td = m_td;
    if (bus.CPU_WR && bus.CPU_ADDR == 2'd1) begin
      iset = 1'b1; td = {7'd0, bus.CPU_DIN[8:0]};
    end else if (m_boot) begin
      iset = 1'b1; td = {7'd0, m_raster};
    end
    if (bus.CPU_WR && bus.CPU_ADDR == 2'd0) m_mask <= bus.CPU_DIN[3:0];
    if (bus.CPU_WR && bus.CPU_ADDR == 2'd1) m_raster <= bus.CPU_DIN[8:0];
    m_pend <= np; m_isv <= ni; m_vec <= vec; m_vv <= vv; m_sel <= sel; m_inack <= inack;
    m_intr <= (elig != 4'd0); m_iset <= iset; m_td <= td;
    m_prev <= bus.IRQ_SRC; m_boot <= 1'b0;
  endtask

  always @(posedge CLK_32M) model_step();

  // compare DUT against model every cycle, mid-period
  always @(negedge CLK_32M) begin
    if (m_valid) begin
      chk("intr",      {31'd0, bus.INTR},      {31'd0, m_intr});
      chk("vec_valid", {31'd0, bus.VEC_VALID}, {31'd0, m_vv});
      chk("vec",       {24'd0, bus.VEC},       {24'd0, m_vec});
      chk("iset",      {31'd0, bus.ISET},      {31'd0, m_iset});
      chk("td",        {16'd0, bus.TD},        {16'd0, m_td});
      chk("dout",      {16'd0, bus.CPU_DOUT},  {16'd0, exp_dout(bus.CPU_ADDR)});
    end
  end

  task automatic tick();
    @(posedge CLK_32M);
    #2;
  endtask

  task automatic wr(input logic [1:0] a, input logic [15:0] d);
    bus.CPU_WR = 1'b1; bus.CPU_ADDR = a; bus.CPU_DIN = d;
    tick();
    bus.CPU_WR = 1'b0;
  endtask

  task automatic ack();
    bus.INTA = 1'b1; tick();
    bus.INTA = 1'b0; tick();
    bus.INTA = 1'b1; tick();
    bus.INTA = 1'b0;
    #1;
  endtask

  task automatic rdchk(input string name, input logic [1:0] a, input logic [15:0] exp);
    bus.CPU_ADDR = a;
    #1;
    chk(name, {16'd0, bus.CPU_DOUT}, {16'd0, exp});
  endtask

  task automatic pin(input string name, input logic act, input logic exp);
    #1;
    chk(name, {31'd0, act}, {31'd0, exp});
  endtask

  initial begin
    bus.CPU_WR = 1'b0; bus.CPU_ADDR = 2'd0; bus.CPU_DIN = 16'd0;
    bus.IRQ_SRC = 4'd0; bus.INTA = 1'b0;
    RESET_N = 1'b0;
    repeat (3) tick();
    RESET_N = 1'b1;
    tick();
    pin("boot_iset", bus.ISET, 1'b1);
    chk("boot_td", {16'd0, bus.TD}, 32'h0);
    rdchk("reset_mask", 2'd0, 16'h000F);
    pin("reset_intr", bus.INTR, 1'b0);
    tick();
    pin("boot_iset_one_cycle", bus.ISET, 1'b0);

    // single source acknowledge
    wr(2'd0, 16'h0000);
    bus.IRQ_SRC = 4'b0010; tick();
    rdchk("pend_b1", 2'd2, 16'h0002);
    tick();
    pin("intr_b1", bus.INTR, 1'b1);
    ack();
    chk("vv_b1", {31'd0, bus.VEC_VALID}, 32'd1);
    chk("vec_b1", {24'd0, bus.VEC}, 32'h21);
    rdchk("pend_after_b1", 2'd2, 16'h0000);
    rdchk("isv_after_b1", 2'd3, 16'h0002);
    tick();
    pin("vv_one_cycle", bus.VEC_VALID, 1'b0);
    pin("intr_drop", bus.INTR, 1'b0);

    // simultaneous bits 0 and 3, bit 3 blocked until EOI
    wr(2'd3, 16'h0000);
    bus.IRQ_SRC = 4'b1011; tick(); tick();
    ack();
    chk("vec_b0_first", {24'd0, bus.VEC}, 32'h20);
    tick(); tick();
    pin("b3_blocked", bus.INTR, 1'b0);
    rdchk("pend_b3", 2'd2, 16'h0008);
    wr(2'd3, 16'h0000);
    tick();
    pin("b3_after_eoi", bus.INTR, 1'b1);
    ack();
    chk("vec_b3", {24'd0, bus.VEC}, 32'h23);
    wr(2'd3, 16'h0000);
    bus.IRQ_SRC = 4'd0; tick();

    // nesting under in_service[1]
    bus.IRQ_SRC = 4'b0010; tick(); tick();
    ack();
    bus.IRQ_SRC = 4'b0110; tick(); tick(); tick();
    pin("b2_blocked_by_b1", bus.INTR, 1'b0);
    rdchk("pend_b2", 2'd2, 16'h0004);
    bus.IRQ_SRC = 4'b0111; tick(); tick();
    pin("b0_nests", bus.INTR, 1'b1);
    ack();
    chk("vec_nested", {24'd0, bus.VEC}, 32'h20);
    rdchk("isv_nested", 2'd3, 16'h0003);
    wr(2'd3, 16'h0000);
    tick(); tick();
    pin("b2_still_blocked", bus.INTR, 1'b0);
    wr(2'd3, 16'h0000);
    tick();
    pin("b2_after_eoi", bus.INTR, 1'b1);
    ack();
    chk("vec_b2", {24'd0, bus.VEC}, 32'h22);
    wr(2'd3, 16'h0000);
    bus.IRQ_SRC = 4'd0; tick();

    // raster loads
    wr(2'd1, 16'h00F0);
    pin("raster_iset", bus.ISET, 1'b1);
    chk("raster_td", {16'd0, bus.TD}, 32'h00F0);
    tick();
    pin("raster_iset_off", bus.ISET, 1'b0);
    bus.CPU_WR = 1'b1; bus.CPU_ADDR = 2'd1; bus.CPU_DIN = 16'h0010; tick();
    pin("b2b_iset1", bus.ISET, 1'b1);
    chk("b2b_td1", {16'd0, bus.TD}, 32'h0010);
    bus.CPU_DIN = 16'h0020; tick();
    pin("b2b_iset2", bus.ISET, 1'b1);
    chk("b2b_td2", {16'd0, bus.TD}, 32'h0020);
    bus.CPU_WR = 1'b0; tick();
    pin("b2b_iset_off", bus.ISET, 1'b0);
    rdchk("raster_rd", 2'd1, 16'h0020);

    // spurious acknowledge, W1C versus coincident edge
    wr(2'd0, 16'h000F);
    bus.IRQ_SRC = 4'b1000; tick(); tick();
    pin("masked_no_intr", bus.INTR, 1'b0);
    ack();
    chk("vec_spurious", {24'd0, bus.VEC}, 32'h27);
    rdchk("pend_spurious", 2'd2, 16'h0008);
    rdchk("isv_spurious", 2'd3, 16'h0000);
    bus.IRQ_SRC = 4'b1010;
    wr(2'd2, 16'h0002);
    rdchk("set_beats_w1c", 2'd2, 16'h000A);
    wr(2'd2, 16'h0008);
    rdchk("w1c_b3", 2'd2, 16'h0002);
    wr(2'd2, 16'h000F);
    bus.IRQ_SRC = 4'd0; tick();

    // reset between the two INTAs abandons the acknowledge
    wr(2'd0, 16'h0000);
    bus.IRQ_SRC = 4'b0001; tick(); tick();
    bus.INTA = 1'b1; tick(); bus.INTA = 1'b0;
    RESET_N = 1'b0; tick();
    RESET_N = 1'b1;
    bus.INTA = 1'b1; tick(); bus.INTA = 1'b0;
    pin("no_vec_after_reset", bus.VEC_VALID, 1'b0);
    chk("vec_cleared", {24'd0, bus.VEC}, 32'h0);
    tick();

    // random traffic
    for (int i = 0; i < 4000; i++) begin
      RESET_N     = ($urandom_range(0, 299) != 0);
      bus.IRQ_SRC = bus.IRQ_SRC ^ (($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'd0);
      bus.INTA    = ($urandom_range(0, 3) == 0);
      bus.CPU_WR  = ($urandom_range(0, 4) == 0);
      bus.CPU_ADDR = 2'($urandom);
      bus.CPU_DIN  = 16'($urandom);
      if (bus.CPU_ADDR == 2'd0 && $urandom_range(0, 3) != 0) bus.CPU_DIN[3:0] = 4'd0;
      if (bus.CPU_ADDR == 2'd2 && $urandom_range(0, 1) != 0) bus.CPU_DIN[3:0] = 4'd0;
      tick();
    end
    bus.CPU_WR = 1'b0; bus.INTA = 1'b0; RESET_N = 1'b1;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
